// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register for the 5-stage RV32I core.
//   - Captures the decoded ID-stage fields.
//   - Detects load-use hazards and inserts a single bubble.
//   - Squashes the ID instruction on a taken branch or jump.
//   - Forwards EX/MEM and MEM/WB results into the ALU operand muxes.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   id_*                  decoded instruction fields from the ID stage
//   flush                 taken branch/jump resolved in EX
//   exmem_*, memwb_*      downstream write-back info used for forwarding
//   stall                 hold PC and IF/ID (combinational)
//   ex_alu_a/b/code       drive the ALU directly
//   ex_store_data         forwarded rs2 value for stores
//   ex_pc, ex_rd, ex_*    registered EX-stage fields and control bits
module id_ex_stage #(
  parameter int          XLEN         = 32,
  parameter int          RA_W         = 5,
  parameter logic [3:0]  NOP_ALU_CODE = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [3:0]      id_alu_code,
  input  logic            id_alusrc_a,
  input  logic            id_alusrc_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic            stall,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_code,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_valid
);

  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rs1_addr;
  logic [RA_W-1:0] ex_rs2_addr;
  logic            ex_alusrc_a;
  logic            ex_alusrc_b;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; hold ID for one cycle.
  always_comb begin
    stall = ex_valid & ex_mem_read & (ex_rd != '0) &
            ((id_uses_rs1 & (ex_rd == id_rs1_addr)) |
             (id_uses_rs2 & (ex_rd == id_rs2_addr)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_code  <= NOP_ALU_CODE;
      ex_alusrc_a  <= 1'b0;
      ex_alusrc_b  <= 1'b0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
    end else if (flush || stall) begin
      // flush takes precedence, but both load the same bubble
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_code  <= NOP_ALU_CODE;
      ex_alusrc_a  <= 1'b0;
      ex_alusrc_b  <= 1'b0;
      ex_imm       <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rd        <= id_rd_addr;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_alu_code  <= id_alu_code;
      ex_alusrc_a  <= id_alusrc_a;
      ex_alusrc_b  <= id_alusrc_b;
      ex_imm       <= id_imm;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs1_addr))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs1_addr))
      fwd_rs1 = memwb_wdata;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs2_addr))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs2_addr))
      fwd_rs2 = memwb_wdata;
  end

  always_comb begin
    ex_alu_a      = ex_alusrc_a ? ex_pc  : fwd_rs1;
    ex_alu_b      = ex_alusrc_b ? ex_imm : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Table-driven vectors for capture/forwarding/operand select, followed by
//   hand-written sequences for load-use stall, flush, x0 and async reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_uses_rs1, id_uses_rs2;
  logic [3:0]  id_alu_code;
  logic        id_alusrc_a, id_alusrc_b, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_wdata;
  logic        stall;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_code;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_alu_code(id_alu_code), .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wdata(memwb_wdata),
    .stall(stall), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_code(ex_alu_code),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_valid(ex_valid)
  );

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [3:0]  code;
    logic        asa, asb, rw, mw;
    logic [4:0]  xm_rd;
    logic        xm_we;
    logic [31:0] xm_res;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_d;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_pc = v.pc;  id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
    id_rs1_addr = v.rs1a; id_rs2_addr = v.rs2a; id_rd_addr = v.rda;
    id_alu_code = v.code; id_alusrc_a = v.asa; id_alusrc_b = v.asb;
    id_reg_write = v.rw; id_mem_write = v.mw;
    exmem_rd = v.xm_rd; exmem_reg_write = v.xm_we; exmem_result = v.xm_res;
    memwb_rd = v.wb_rd; memwb_reg_write = v.wb_we; memwb_wdata = v.wb_d;
  endtask

  task automatic clear_all();
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_alu_code = '0;
    id_alusrc_a = 1'b0; id_alusrc_b = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_wdata = '0;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // lw x7, 0(x1) presented in ID
  task automatic present_lw(input logic [4:0] rd);
    clear_all();
    id_pc = 32'h200; id_rs1_addr = 5'd1; id_rs1_data = 32'h40;
    id_alusrc_b = 1'b1; id_rd_addr = rd; id_reg_write = 1'b1;
    id_mem_read = 1'b1; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    //          pc      rs1d       rs2d      imm      rs1a rs2a rd  code  asa asb rw mw  xm_rd xm_we xm_res        wb_rd wb_we wb_d       exp_a        exp_b      exp_st
    vecs[0] = '{32'h100, 32'd10,   32'd20,   32'h0,    5'd1, 5'd2, 5'd3, 4'h0, 0, 0, 1, 0, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'd10,      32'd20,    32'd20};
    vecs[1] = '{32'h104, 32'h100,  32'h77,   32'h5,    5'd1, 5'd9, 5'd4, 4'h0, 0, 1, 1, 0, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'h100,     32'h5,     32'h77};
    vecs[2] = '{32'h108, 32'h1,    32'h4,    32'h0,    5'd5, 5'd1, 5'd6, 4'h8, 0, 0, 1, 0, 5'd5, 1, 32'h64,        5'd5, 1, 32'h11,     32'h64,      32'h4,     32'h4};
    vecs[3] = '{32'h10c, 32'h3,    32'h2,    32'h0,    5'd8, 5'd6, 5'd10,4'h7, 0, 0, 1, 0, 5'd7, 1, 32'hAAAA,      5'd6, 1, 32'h33,     32'h3,       32'h33,    32'h33};
    vecs[4] = '{32'h110, 32'h1,    32'h9,    32'h0,    5'd5, 5'd2, 5'd11,4'h1, 0, 0, 1, 0, 5'd5, 0, 32'h64,        5'd5, 1, 32'h11,     32'h11,      32'h9,     32'h9};
    vecs[5] = '{32'h114, 32'h55,   32'h6,    32'h0,    5'd5, 5'd3, 5'd12,4'h2, 0, 0, 1, 0, 5'd0, 0, 32'h0,         5'd5, 0, 32'h11,     32'h55,      32'h6,     32'h6};
    vecs[6] = '{32'h118, 32'h0,    32'h0,    32'h0,    5'd0, 5'd0, 5'd0, 4'h0, 0, 0, 1, 0, 5'd0, 1, 32'hFFFF_FFFF, 5'd0, 1, 32'h1234,   32'h0,       32'h0,     32'h0};
    vecs[7] = '{32'h1000,32'h99,   32'h0,    32'h2000, 5'd3, 5'd0, 5'd13,4'h0, 1, 1, 1, 0, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'h1000,    32'h2000,  32'h0};
    vecs[8] = '{32'h120, 32'h200,  32'h1,    32'h8,    5'd2, 5'd5, 5'd0, 4'h0, 0, 1, 0, 1, 5'd5, 1, 32'hCAFE,      5'd0, 0, 32'h0,      32'h200,     32'h8,     32'hCAFE};
    vecs[9] = '{32'h124, 32'h7,    32'h8,    32'h0,    5'd3, 5'd4, 5'd14,4'h4, 0, 0, 1, 0, 5'd4, 1, 32'h400,       5'd3, 1, 32'h300,    32'h300,     32'h400,   32'h400};

    clear_all();
    reset = 1'b1;
    #2;
    chk("reset_valid",   {31'b0, ex_valid},     32'd0);
    chk("reset_code",    {28'b0, ex_alu_code},  32'd0);
    chk("reset_alu_a",   ex_alu_a,              32'd0);
    chk("reset_stall",   {31'b0, stall},        32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      clear_all();
      id_uses_rs1 = 1'b1;
      id_uses_rs2 = 1'b1;
      apply(vecs[i]);
      edge_sample();
      chk($sformatf("v%0d_alu_a", i),  ex_alu_a,      vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i),  ex_alu_b,      vecs[i].exp_b);
      chk($sformatf("v%0d_store", i),  ex_store_data, vecs[i].exp_st);
      chk($sformatf("v%0d_code", i),   {28'b0, ex_alu_code}, {28'b0, vecs[i].code});
      chk($sformatf("v%0d_pc", i),     ex_pc,         vecs[i].pc);
      chk($sformatf("v%0d_rd", i),     {27'b0, ex_rd}, {27'b0, vecs[i].rda});
      chk($sformatf("v%0d_rw", i),     {31'b0, ex_reg_write}, {31'b0, vecs[i].rw});
      chk($sformatf("v%0d_mw", i),     {31'b0, ex_mem_write}, {31'b0, vecs[i].mw});
      chk($sformatf("v%0d_valid", i),  {31'b0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_stall", i),  {31'b0, stall},    32'd0);
    end

    // load-use: lw x7 then and x8,x7,x2
    @(negedge clk);
    present_lw(5'd7);
    edge_sample();
    chk("lu_ex_mem_read", {31'b0, ex_mem_read}, 32'd1);
    @(negedge clk);
    clear_all();
    id_pc = 32'h204; id_rs1_addr = 5'd7; id_rs1_data = 32'h0;
    id_rs2_addr = 5'd2; id_rs2_data = 32'h5; id_rd_addr = 5'd8;
    id_reg_write = 1'b1; id_alu_code = 4'h2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    chk("lu_stall_on", {31'b0, stall}, 32'd1);
    edge_sample();
    chk("lu_bubble_valid", {31'b0, ex_valid},     32'd0);
    chk("lu_bubble_rw",    {31'b0, ex_reg_write}, 32'd0);
    chk("lu_bubble_code",  {28'b0, ex_alu_code},  32'd0);
    chk("lu_bubble_rd",    {27'b0, ex_rd},        32'd0);
    chk("lu_stall_off",    {31'b0, stall},        32'd0);
    @(negedge clk);
    memwb_rd = 5'd7; memwb_reg_write = 1'b1; memwb_wdata = 32'hDEAD_BEEF;
    edge_sample();
    chk("lu_fwd_alu_a", ex_alu_a, 32'hDEAD_BEEF);
    chk("lu_fwd_alu_b", ex_alu_b, 32'h5);
    chk("lu_fwd_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_fwd_code",  {28'b0, ex_alu_code}, 32'h2);
    chk("lu_fwd_stall", {31'b0, stall}, 32'd0);

    // load to x0 never stalls
    @(negedge clk);
    present_lw(5'd0);
    edge_sample();
    @(negedge clk);
    clear_all();
    id_uses_rs1 = 1'b1; id_rs1_addr = 5'd0;
    #1;
    chk("x0_load_no_stall", {31'b0, stall}, 32'd0);

    // matching address but source not used: no stall
    @(negedge clk);
    present_lw(5'd7);
    edge_sample();
    @(negedge clk);
    clear_all();
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd7;
    #1;
    chk("unused_src_no_stall", {31'b0, stall}, 32'd0);
    id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_use_stall", {31'b0, stall}, 32'd1);

    // flush together with stall: sw x7,4(x1) behind lw x7
    @(negedge clk);
    present_lw(5'd7);
    edge_sample();
    @(negedge clk);
    clear_all();
    id_rs1_addr = 5'd1; id_rs2_addr = 5'd7; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_imm = 32'h4; id_alusrc_b = 1'b1; id_mem_write = 1'b1; id_alu_code = 4'h3;
    flush = 1'b1;
    #1;
    chk("fs_stall_on", {31'b0, stall}, 32'd1);
    edge_sample();
    chk("fs_valid", {31'b0, ex_valid},     32'd0);
    chk("fs_mw",    {31'b0, ex_mem_write}, 32'd0);
    chk("fs_code",  {28'b0, ex_alu_code},  32'd0);

    // flush alone
    @(negedge clk);
    clear_all();
    id_pc = 32'h300; id_rd_addr = 5'd9; id_reg_write = 1'b1; id_alu_code = 4'h5;
    flush = 1'b1;
    edge_sample();
    chk("fl_valid", {31'b0, ex_valid},     32'd0);
    chk("fl_rw",    {31'b0, ex_reg_write}, 32'd0);
    chk("fl_code",  {28'b0, ex_alu_code},  32'd0);
    chk("fl_pc",    ex_pc,                 32'd0);

    // async reset mid-run with a store in EX
    @(negedge clk);
    clear_all();
    id_pc = 32'h400; id_rs1_addr = 5'd1; id_rs1_data = 32'h10;
    id_rs2_addr = 5'd2; id_rs2_data = 32'h20; id_imm = 32'h8;
    id_alusrc_b = 1'b1; id_mem_write = 1'b1; id_alu_code = 4'h6;
    edge_sample();
    chk("pre_rst_valid", {31'b0, ex_valid},     32'd1);
    chk("pre_rst_mw",    {31'b0, ex_mem_write}, 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, ex_valid},     32'd0);
    chk("rst_mw",    {31'b0, ex_mem_write}, 32'd0);
    chk("rst_code",  {28'b0, ex_alu_code},  32'd0);
    chk("rst_alu_a", ex_alu_a,              32'd0);
    chk("rst_alu_b", ex_alu_b,              32'd0);
    chk("rst_store", ex_store_data,         32'd0);
    chk("rst_stall", {31'b0, stall},        32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
